// File: rtl/cpu_axi_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_axi_arbiter
//   Shares a single AXI master port between the instruction-fetch and the
//   data-memory SRAM-like requesters of the pipelined MIPS core. Only one
//   transaction is ever outstanding; the addr_ok/data_ok handshakes become the
//   fetch-stall and memory-stall inputs of the hazard unit.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous requests are granted
//                        alternately (last_owner register, reset = inst).
//                        When undefined, data always wins over inst.
//
// Ports:
//   clk, rst                  core clock, synchronous active-high reset
//   inst_*                    fetch requester (read only, word size)
//   data_*                    memory-stage requester (load/store, byte/half/word)
//   ar*/r*                    AXI read address / read data channels
//   aw*/w*/b*                 AXI write address / write data / write response
//   Burst fields (len=0, burst=INCR) are tied off by the wrapper.
// ---------------------------------------------------------------------------
module cpu_axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  // memory side
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  // AXI read address
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // AXI write address
  output logic [ADDR_W-1:0] awaddr,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  // AXI write data
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  // AXI write response
  input  logic              bvalid,
  output logic              bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              gnt_data, gnt_inst;

  // rid is not needed: a single read is outstanding, so the owner register
  // already identifies the returning beat.
  logic unused_rid;
  assign unused_rid = ^rid;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q, last_owner_d;
`endif

  // -------------------------------------------------------------------------
  // Grant selection (only meaningful in IDLE)
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_data = 1'b0;
    gnt_inst = 1'b0;
    if (state_q == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (data_req && inst_req) begin
        // whoever was not served last wins a tie
        gnt_data = (last_owner_q == OWN_INST);
        gnt_inst = ~gnt_data;
      end else begin
        gnt_data = data_req;
        gnt_inst = inst_req;
      end
`else
      gnt_data = data_req;
      gnt_inst = inst_req & ~data_req;
`endif
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_owner_d = last_owner_q;
    if (gnt_data)      last_owner_d = OWN_DATA;
    else if (gnt_inst) last_owner_d = OWN_INST;
  end

  always_ff @(posedge clk) begin
    if (rst) last_owner_q <= OWN_INST;
    else     last_owner_q <= last_owner_d;
  end
`endif

  // -------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;

    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (gnt_data || gnt_inst) begin
          inst_addr_ok = gnt_inst;
          data_addr_ok = gnt_data;
          owner_d      = gnt_data ? OWN_DATA : OWN_INST;
          addr_d       = gnt_data ? data_addr : inst_addr;
          size_d       = gnt_data ? data_size : 2'd2;
          wdata_d      = data_wdata;
          // direction is captured by the state we branch to
          state_d      = (gnt_data && data_wr) ? WR_ADDR : RD_ADDR;
        end
      end

      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end

      RD_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          inst_data_ok = (owner_q == OWN_INST);
          data_data_ok = (owner_q == OWN_DATA);
          state_d      = IDLE;
        end
      end

      WR_ADDR: begin
        // the two channels complete independently; each valid drops once
        // its own handshake has been seen
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q  | (wvalid & wready);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end

      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_data_ok = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_INST;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // -------------------------------------------------------------------------
  // AXI field drive from the latched request
  // -------------------------------------------------------------------------
  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      2'd2:    wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  assign arid       = {3'b000, owner_q};
  assign araddr     = addr_q;
  assign arsize     = {1'b0, size_q};
  assign awaddr     = addr_q;
  assign awsize     = {1'b0, size_q};
  assign wdata      = wdata_q;
  assign wlast      = wvalid;
  // read data is only meaningful while the matching data_ok is high
  assign inst_rdata = rdata;
  assign data_rdata = rdata;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
module tb_cpu_axi_arbiter;

  logic        clk, rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic        bvalid, bready;

  cpu_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  // advance to just after the next rising edge; inputs are changed here and
  // outputs sampled #1 later, well away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bvalid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, inst_data_ok,
         data_addr_ok, data_data_ok} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0", {arvalid, rready, awvalid, wvalid, bready,
               inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
    end
    checks++;
    if ({arid, araddr} !== 36'h0) begin
      errors++;
      $display("FAIL reset_latched got arid %h araddr %h exp 0", arid, araddr);
    end
  endtask

  task automatic test_inst_fetch();
    tick();
    inst_req = 1; inst_addr = 32'hbfc00000; arready = 1;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL fetch_addr_ok got %b exp 10", {inst_addr_ok, data_addr_ok});
    end
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h3c1d8000});
    tick();
    inst_req = 0;
    #1;
    checks++;
    if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'hbfc00000, 3'd2}) begin
      errors++;
      $display("FAIL fetch_ar got v%b id%h a%h s%h exp v1 id0 abfc00000 s2", arvalid, arid, araddr, arsize);
    end
    tick();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'h3c1d8000;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL fetch_rsp got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if ({rready, inst_data_ok, data_data_ok, inst_rdata} !== {1'b1, !e.is_data, e.is_data, e.rdata}) begin
        errors++;
        $display("FAIL fetch_rsp got rr%b iok%b dok%b %h exp rr1 iok1 dok0 %h",
                 rready, inst_data_ok, data_data_ok, inst_rdata, e.rdata);
      end
    end
    tick();
    rvalid = 0; rlast = 0; rdata = 0;
    #1;
    checks++;
    if ({inst_data_ok, arvalid, rready, awvalid, wvalid, data_data_ok} !== 6'b0) begin
      errors++; $display("FAIL fetch_done got %b exp 0",
                         {inst_data_ok, arvalid, rready, awvalid, wvalid, data_data_ok});
    end
  endtask

  task automatic test_priority();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000010;
    inst_req = 1; inst_addr = 32'hbfc00004;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      errors++; $display("FAIL prio_grant got %b exp 01", {inst_addr_ok, data_addr_ok});
    end
    exp_q.push_back('{is_data: 1'b1, rdata: 32'h11112222});
    tick();
    data_req = 0; arready = 1;
    #1;
    checks++;
    if ({arvalid, arid, araddr, inst_addr_ok} !== {1'b1, 4'd1, 32'h80000010, 1'b0}) begin
      errors++; $display("FAIL prio_ar got v%b id%h a%h iok%b", arvalid, arid, araddr, inst_addr_ok);
    end
    tick();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'h11112222;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL prio_rsp got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if ({inst_data_ok, data_data_ok, data_rdata, inst_addr_ok} !== {!e.is_data, e.is_data, e.rdata, 1'b0}) begin
        errors++;
        $display("FAIL prio_rsp got iok%b dok%b %h iaok%b exp iok0 dok1 %h iaok0",
                 inst_data_ok, data_data_ok, data_rdata, inst_addr_ok, e.rdata);
      end
    end
    tick();
    rvalid = 0; rlast = 0; rdata = 0;
    #1;
    checks++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      errors++; $display("FAIL prio_bubble got %b exp 10", {inst_addr_ok, data_addr_ok});
    end
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h22223333});
    tick();
    inst_req = 0; arready = 1;
    #1;
    checks++;
    if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'hbfc00004}) begin
      errors++; $display("FAIL prio_ar2 got v%b id%h a%h", arvalid, arid, araddr);
    end
    tick();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'h22223333;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL prio_rsp2 got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if ({inst_data_ok, data_data_ok, inst_rdata} !== {!e.is_data, e.is_data, e.rdata}) begin
        errors++; $display("FAIL prio_rsp2 got iok%b dok%b %h exp %h",
                           inst_data_ok, data_data_ok, inst_rdata, e.rdata);
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_byte_store();
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003; data_wdata = 32'haaaaaaaa;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL bst_addr_ok got %b exp 1", data_addr_ok);
    end
    exp_q.push_back('{is_data: 1'b1, rdata: 32'h0});
    tick();
    data_req = 0; data_wr = 0; awready = 1;
    #1;
    checks++;
    if ({awvalid, wvalid, wlast, wstrb, awsize, awaddr, wdata} !==
        {1'b1, 1'b1, 1'b1, 4'b1000, 3'd0, 32'h80000003, 32'haaaaaaaa}) begin
      errors++;
      $display("FAIL bst_aw got awv%b wv%b wl%b strb%b sz%h a%h d%h", awvalid, wvalid, wlast,
               wstrb, awsize, awaddr, wdata);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      awready = 0;
      wready = (c == 1);
      #1;
      checks++;
      if ({awvalid, wvalid, bready} !== 3'b010) begin
        errors++; $display("FAIL bst_wwait%0d got awv%b wv%b br%b exp 010", c, awvalid, wvalid, bready);
      end
    end
    tick();
    wready = 0;
    #1;
    checks++;
    if ({wvalid, bready, data_data_ok} !== 3'b010) begin
      errors++; $display("FAIL bst_resp_wait got wv%b br%b dok%b exp 010", wvalid, bready, data_data_ok);
    end
    tick();
    bvalid = 1;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL bst_rsp got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if ({inst_data_ok, data_data_ok} !== {!e.is_data, e.is_data}) begin
        errors++; $display("FAIL bst_rsp got iok%b dok%b exp 01", inst_data_ok, data_data_ok);
      end
    end
    tick();
    bvalid = 0;
    #1;
    checks++;
    if ({data_data_ok, bready, awvalid, wvalid} !== 4'b0) begin
      errors++; $display("FAIL bst_done got %b exp 0", {data_data_ok, bready, awvalid, wvalid});
    end
  endtask

  task automatic test_half_then_load();
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h80000002; data_wdata = 32'h55556666;
    tick();
    data_req = 0; data_wr = 0; awready = 1; wready = 1;
    #1;
    checks++;
    if ({awvalid, wvalid, wstrb, awsize, awaddr} !== {1'b1, 1'b1, 4'b1100, 3'd1, 32'h80000002}) begin
      errors++; $display("FAIL hst_aw got awv%b wv%b strb%b sz%h a%h", awvalid, wvalid, wstrb, awsize, awaddr);
    end
    exp_q.push_back('{is_data: 1'b1, rdata: 32'h0});
    tick();
    awready = 0; wready = 0; bvalid = 1;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL hst_rsp got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if ({awvalid, wvalid, data_data_ok, inst_data_ok} !== {2'b00, e.is_data, !e.is_data}) begin
        errors++; $display("FAIL hst_rsp got awv%b wv%b dok%b iok%b exp 0010",
                           awvalid, wvalid, data_data_ok, inst_data_ok);
      end
    end
    tick();
    bvalid = 0;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000004;
    #1;
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++; $display("FAIL ld_addr_ok got %b exp 1", data_addr_ok);
    end
    exp_q.push_back('{is_data: 1'b1, rdata: 32'hdeadbeef});
    tick();
    data_req = 0; arready = 1;
    #1;
    checks++;
    if ({arvalid, arid, arsize, araddr} !== {1'b1, 4'd1, 3'd2, 32'h80000004}) begin
      errors++; $display("FAIL ld_ar got v%b id%h s%h a%h", arvalid, arid, arsize, araddr);
    end
    tick();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'hdeadbeef; rid = 4'd1;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL ld_rsp got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if ({data_data_ok, inst_data_ok, data_rdata} !== {e.is_data, !e.is_data, e.rdata}) begin
        errors++; $display("FAIL ld_rsp got dok%b iok%b %h exp %h", data_data_ok, inst_data_ok,
                           data_rdata, e.rdata);
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_addr = 32'hbfc00100;
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h0});
    tick();
    inst_req = 0; arready = 1;
    tick();
    arready = 0;
    #1;
    checks++;
    if (rready !== 1'b1) begin
      errors++; $display("FAIL rmid_in_rd got rready %b exp 1", rready);
    end
    rst = 1;
    tick();
    rst = 0;
    // the abandoned read will never answer
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    #1;
    checks++;
    if ({arvalid, rready, awvalid, wvalid, bready, inst_addr_ok, inst_data_ok,
         data_addr_ok, data_data_ok} !== 9'b0) begin
      errors++; $display("FAIL rmid_idle got %b exp 0", {arvalid, rready, awvalid, wvalid, bready,
                         inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
    end
    inst_req = 1; inst_addr = 32'hbfc00200;
    #1;
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++; $display("FAIL rmid_regrant got %b exp 1", inst_addr_ok);
    end
    exp_q.push_back('{is_data: 1'b0, rdata: 32'h01234567});
    tick();
    inst_req = 0; arready = 1;
    #1;
    checks++;
    if ({arvalid, araddr} !== {1'b1, 32'hbfc00200}) begin
      errors++; $display("FAIL rmid_ar got v%b a%h", arvalid, araddr);
    end
    tick();
    arready = 0; rvalid = 1; rlast = 1; rdata = 32'h01234567;
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL rmid_rsp got empty scoreboard exp entry");
    end else begin
      e = exp_q.pop_front();
      if ({inst_data_ok, data_data_ok, inst_rdata} !== {!e.is_data, e.is_data, e.rdata}) begin
        errors++; $display("FAIL rmid_rsp got iok%b dok%b %h exp %h", inst_data_ok, data_data_ok,
                           inst_rdata, e.rdata);
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_arbitration();
    logic [3:0] exp_order;
    logic       got;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;   // bit i = 1 means data granted in transaction i
`else
    exp_order = 4'b1111;
`endif
    rst = 1;
    tick();
    rst = 0;
    inst_req = 1; inst_addr = 32'hbfc00300;
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80000300;
    for (int i = 0; i < 4; i++) begin
      #1;
      got = data_addr_ok;
      checks++;
      if ((inst_addr_ok ^ data_addr_ok) !== 1'b1 || got !== exp_order[i]) begin
        errors++; $display("FAIL arb_grant%0d got iok%b dok%b exp data=%b", i, inst_addr_ok,
                           data_addr_ok, exp_order[i]);
      end
      exp_q.push_back('{is_data: got, rdata: 32'hc0de0000 + 32'(i)});
      tick();
      arready = 1;
      tick();
      arready = 0; rvalid = 1; rlast = 1; rdata = 32'hc0de0000 + 32'(i);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL arb_rsp%0d got empty scoreboard exp entry", i);
      end else begin
        e = exp_q.pop_front();
        if ({inst_data_ok, data_data_ok, (e.is_data ? data_rdata : inst_rdata)} !==
            {!e.is_data, e.is_data, e.rdata}) begin
          errors++; $display("FAIL arb_rsp%0d got iok%b dok%b exp %h", i, inst_data_ok,
                             data_data_ok, e.rdata);
        end
      end
      tick();
      rvalid = 0; rlast = 0; rdata = 0;
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_inst_fetch();
    test_priority();
    test_byte_store();
    test_half_then_load();
    test_reset_mid();
    test_arbitration();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL sb_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_axi_arbiter.md
Name: cpu_axi_arbiter

Overview:
- Shares one AXI master port between the instruction-fetch and data-memory SRAM-like requesters of the pipelined MIPS core.
- Data requests have priority over instruction requests.
- At most one transaction is outstanding at a time.
- Its addr_ok/data_ok handshakes are what fetch and memory-stage logic turn into the fetch-stall and memory-stall inputs of the hazard unit.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width (fixed 32; wstrb is 4 bits).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request (read only)
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted
- inst_data_ok  out  1  fetch data valid
- inst_rdata  out  32  fetch data
- data_req  in  1  memory request
- data_wr  in  1  1=store, 0=load
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  32  memory address
- data_wdata  in  32  store data
- data_addr_ok  out  1  memory request accepted
- data_data_ok  out  1  load data valid / store completed
- data_rdata  out  32  load data
- arid  out  4  0 inst, 1 data
- araddr  out  32;  arsize  out  3;  arvalid  out  1;  arready  in  1
- rid  in  4;  rdata  in  32;  rlast  in  1;  rvalid  in  1;  rready  out  1
- awaddr  out  32;  awsize  out  3;  awvalid  out  1;  awready  in  1
- wdata  out  32;  wstrb  out  4;  wlast  out  1;  wvalid  out  1;  wready  in  1
- bvalid  in  1;  bready  out  1

Behaviour:
- Clock, reset: one clock; reset is synchronous and active-high, ports clk and rst. Reset mid-transaction abandons it and returns to IDLE.
- Reset values: state IDLE; every valid/ready output and every ok output 0; latched request and owner 0.
- AXI burst fields are tied off by the wrapper: len=0, burst=INCR. wlast=1 whenever wvalid. arsize/awsize = {1'b0, size}; inst size = 2.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE:
  - Grant goes to data_req if set, else to inst_req.
  - addr_ok for the winner is combinational (state==IDLE & granted req).
  - On that edge, latch addr/size/wr/wdata and owner. Next state: RD_ADDR, or WR_ADDR for a data store.
  - The loser sees addr_ok=0 and must hold its request.
- RD_ADDR: arvalid=1 with the latched fields; arid = owner. arvalid&arready -> RD_DATA.
- RD_DATA:
  - rready=1. On rvalid&rlast, the owner's data_ok pulses combinationally for exactly that cycle. Owner's rdata = AXI rdata. Next state IDLE.
  - rid is ignored, since only one read is outstanding.
- WR_ADDR:
  - awvalid and wvalid are both raised on entry. Each drops independently once its handshake completes; flags aw_done/w_done record this. Handshakes may occur in the same or different cycles.
  - When both are done (counting a handshake in the current cycle) -> WR_RESP.
- WR_RESP: bready=1. On bvalid, data_data_ok pulses and the state goes to IDLE. bresp is ignored.
- No new grant is issued in the cycle data_ok pulses. Minimum turnaround is a one-cycle bubble in IDLE.
- wstrb:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: addr[1] ? 4'b1100 : 4'b0011
  - size 2: 4'b1111
  - size 3: 4'b0000, no lanes written (illegal, caught upstream)
- wdata is driven as given; store data is already lane-replicated by the memory stage.
- Unaligned addresses are not checked; address exceptions are raised upstream before the request.
- inst_rdata/data_rdata are valid only while the matching data_ok is high.

Optional Feature:
- ARB_ROUND_ROBIN_EN.
- Defined: grant in IDLE alternates. A last_owner register (reset = inst) gives priority to the requester that was not granted last, when both request in the same cycle.
- Undefined: fixed data-over-inst priority; last_owner is not implemented.

Test Plan:
- inst_req, addr 0xbfc00000, with arready=1 and rvalid next cycle returning 0x3c1d8000 -> inst_addr_ok in cycle 0; arvalid/araddr 0xbfc00000/arid 0; inst_data_ok one cycle with inst_rdata 0x3c1d8000; no data outputs active.
- data_req and inst_req in the same cycle (feature off) -> data_addr_ok=1, inst_addr_ok=0. Inst is granted only after data_data_ok plus a one-cycle IDLE bubble.
- Byte store, addr 0x80000003, wdata 0xaaaaaaaa; awready 2 cycles before wready -> wstrb 4'b1000, awsize 0. awvalid drops after its handshake while wvalid stays high until wready; after bvalid, data_data_ok is 1 for one cycle.
- Half store at 0x80000002, then word load at 0x80000004 -> wstrb 4'b1100, awsize 1; the load shows arid 1, arsize 2, data_rdata returned with data_data_ok.
- rst asserted in RD_DATA -> the next cycle has state IDLE and all valid/ready/ok outputs 0; the following inst_req is accepted normally.
- ARB_ROUND_ROBIN_EN: both requesters held continuously for 4 transactions -> grant order data, inst, data, inst. Feature off: data, data, data, data.
